cpu_speed_sequencer: RTL and testbench
======================================

CPU_SPEED_SEQUENCER -- requirements
Module: cpu_speed_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 8: clk_28 cycles held after each speed-bit change before the next step.
REQ-002 Parameter HOLD_TIMEOUT, default 255: max clk_28 cycles spent waiting for cpu_safe before a forced switch.
REQ-003 clk_28  input  1  sole clock, 28 MHz machine clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 speed_req  input  2  requested CPU speed: 00=3.5, 01=7, 10=14, 11=28 MHz.
REQ-006 speed_req_valid  input  1  one-cycle strobe qualifying speed_req.
REQ-007 cpu_safe  input  1  high when the CPU is between bus cycles and a clock switch is safe.
REQ-008 contend_in  input  1  raw memory-contention request from the video timing.
REQ-009 contention_en  input  1  contention enable from the machine configuration register.
REQ-010 cpu_speed  output  2  select lines for the CPU clock mux tree.
REQ-011 cpu_clk_lsb  output  1  3.5 MHz phase bit for the contended clock generator.
REQ-012 cpu_contend  output  1  qualified contention request to the contended clock generator.
REQ-013 busy  output  1  high while a speed change is in progress or pending.
REQ-014 speed_ack  output  1  one-cycle pulse when cpu_speed reaches the target value.
REQ-015 timeout_flag  output  1  sticky; set when a switch was forced by HOLD_TIMEOUT.

Function
REQ-016 A free-running 3-bit phase counter SHALL increment every clk_28 cycle; cpu_clk_lsb = phase[2] (toggles every 4 cycles, period 8).
REQ-017 FSM states SHALL be IDLE, HOLD, SW_LO, SETTLE_LO, SW_HI, SETTLE_HI, DONE.
REQ-018 IDLE: on speed_req_valid with speed_req != cpu_speed, latch target and go to HOLD; an equal request SHALL produce speed_ack one cycle later with no state change.
REQ-019 HOLD: proceed to SW_LO when cpu_safe=1 and phase==0, or when the hold counter reaches HOLD_TIMEOUT (set timeout_flag).
REQ-020 SW_LO: if target[0] != cpu_speed[0], update cpu_speed[0] and go to SETTLE_LO; otherwise go directly to SW_HI.
REQ-021 SETTLE_LO: count exactly SETTLE_CYCLES cycles, then go to SW_HI.
REQ-022 SW_HI: if target[1] != cpu_speed[1], update cpu_speed[1] and go to SETTLE_HI; otherwise go to DONE.
REQ-023 SETTLE_HI: count SETTLE_CYCLES cycles, then go to DONE.
REQ-024 DONE: assert speed_ack for one cycle; if a pending request exists and differs from cpu_speed, load it and go to HOLD, else go to IDLE.
REQ-025 cpu_speed bit 0 SHALL always change before bit 1; both bits never change in the same cycle.
REQ-026 speed_req_valid outside IDLE SHALL overwrite a single pending slot (newest wins); it is never dropped silently and never alters the in-flight target.
REQ-027 busy = (state != IDLE) or pending valid.
REQ-028 cpu_contend SHALL be registered: contend_in & contention_en & (cpu_speed==00) & ~busy, one-cycle latency.
REQ-029 Simultaneous speed_req_valid and DONE: the new request SHALL become the pending request and be serviced immediately from DONE.
REQ-030 Hold and settle counters SHALL saturate, never wrap.

Reset
REQ-031 reset SHALL asynchronously force: state IDLE, cpu_speed=00, phase=0, cpu_clk_lsb=0, cpu_contend=0, busy=0, speed_ack=0, timeout_flag=0, pending cleared.
REQ-032 Reset asserted mid-sequence SHALL abandon the change; after release cpu_speed=00 regardless of prior target.
REQ-033 timeout_flag SHALL clear only on reset.

Structure
REQ-034 Speed encodings (SPEED_3M5, SPEED_7, SPEED_14, SPEED_28) and state encoding SHALL live in a shared package used by the config-register block.
REQ-035 One sub-module, cpu_phase_gen (phase counter and cpu_clk_lsb), SHALL be instantiated; everything else is flat.

Verification
REQ-036 Reset, then req 11 with cpu_safe=1 -> cpu_speed 00->01 at SW_LO, ->11 after exactly 8 settle cycles, speed_ack after second settle, busy low next cycle.
REQ-037 req 01 from 11 -> bit0 unchanged (no SETTLE_LO), bit1 cleared, total one settle period.
REQ-038 cpu_safe held 0, req 10 -> forced switch after 255 hold cycles, timeout_flag=1 until reset.
REQ-039 req 01 then req 10 and 11 while busy -> 01 completes, then 11 applied; 10 never appears on cpu_speed.
REQ-040 contend_in=1, contention_en=1, speed 00 idle -> cpu_contend=1 one cycle later; request to 01 -> cpu_contend=0 while busy and after.
REQ-041 reset asserted during SETTLE_HI -> cpu_speed=00 immediately (async), no speed_ack, busy=0.

Source files
------------

// File: rtl/cpu_speed_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cpu_speed_sequencer_pkg
// Shared encodings for the CPU speed sequencer and the configuration-register
// block: CPU speed select codes, sequencer state encoding, phase width and a
// small helper that qualifies memory contention.
// -----------------------------------------------------------------------------
package cpu_speed_sequencer_pkg;

    // CPU clock select codes driven onto the clock mux tree.
    typedef enum logic [1:0] {
        SPEED_3M5 = 2'b00,
        SPEED_7   = 2'b01,
        SPEED_14  = 2'b10,
        SPEED_28  = 2'b11
    } speed_t;

    // Sequencer states. Bit 0 of the speed select is always switched (and
    // allowed to settle) before bit 1, so the mux never sees both change.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLD      = 3'd1,
        ST_SW_LO     = 3'd2,
        ST_SETTLE_LO = 3'd3,
        ST_SW_HI     = 3'd4,
        ST_SETTLE_HI = 3'd5,
        ST_DONE      = 3'd6
    } seq_state_t;

    localparam int PHASE_W = 3;

    // Contention only applies to the slowest (ULA-compatible) speed and never
    // while a speed change is in progress or pending.
    function automatic logic contention_allowed(input logic [1:0] speed,
                                                input logic       seq_busy);
        return (speed == SPEED_3M5) && !seq_busy;
    endfunction

endpackage

// File: rtl/cpu_speed_sequencer_phase_gen.sv
// -----------------------------------------------------------------------------
// cpu_phase_gen
// Free-running 3-bit phase counter on the 28 MHz clock. Its MSB is the
// 3.5 MHz phase bit used by the contended clock generator.
// Ports:
//   clk_28       in   28 MHz machine clock
//   reset        in   asynchronous active-high reset
//   phase        out  current phase count (0..7)
//   cpu_clk_lsb  out  phase[2]: toggles every 4 cycles, period 8
// -----------------------------------------------------------------------------
module cpu_phase_gen
    import cpu_speed_sequencer_pkg::*;
(
    input  logic               clk_28,
    input  logic               reset,
    output logic [PHASE_W-1:0] phase,
    output logic               cpu_clk_lsb
);

    logic [PHASE_W-1:0] r_phase;

    // Phase counter, wraps naturally every 8 cycles.
    always_ff @(posedge clk_28 or posedge reset) begin
        if (reset) begin
            r_phase <= {PHASE_W{1'b0}};
        end else begin
            r_phase <= r_phase + {{(PHASE_W-1){1'b0}}, 1'b1};
        end
    end

    assign phase       = r_phase;
    assign cpu_clk_lsb = r_phase[PHASE_W-1];

endmodule

// File: rtl/cpu_speed_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_speed_sequencer
// Glitch-safe CPU clock speed switcher. A speed request waits until the CPU is
// between bus cycles on phase 0 (or a hold timeout expires), then changes the
// speed select one bit at a time, low bit first, with a settle period after
// each change. One pending slot holds the newest request received mid-change.
// Ports:
//   clk_28           in   28 MHz machine clock (sole clock)
//   reset            in   asynchronous active-high reset
//   speed_req[1:0]   in   requested speed 00=3.5 01=7 10=14 11=28 MHz
//   speed_req_valid  in   one-cycle strobe qualifying speed_req
//   cpu_safe         in   CPU is between bus cycles
//   contend_in       in   raw contention request from video timing
//   contention_en    in   contention enable from configuration
//   cpu_speed[1:0]   out  clock mux select
//   cpu_clk_lsb      out  3.5 MHz phase bit
//   cpu_contend      out  qualified contention request (registered)
//   busy             out  change in progress or pending
//   speed_ack        out  one-cycle pulse when the target speed is reached
//   timeout_flag     out  sticky: a switch was forced by the hold timeout
// Parameters: SETTLE_CYCLES (>=1), HOLD_TIMEOUT (>=1).
// -----------------------------------------------------------------------------
module cpu_speed_sequencer
    import cpu_speed_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int HOLD_TIMEOUT  = 255
)
(
    input  logic       clk_28,
    input  logic       reset,
    input  logic [1:0] speed_req,
    input  logic       speed_req_valid,
    input  logic       cpu_safe,
    input  logic       contend_in,
    input  logic       contention_en,
    output logic [1:0] cpu_speed,
    output logic       cpu_clk_lsb,
    output logic       cpu_contend,
    output logic       busy,
    output logic       speed_ack,
    output logic       timeout_flag
);

    localparam int HOLD_W = $clog2(HOLD_TIMEOUT + 1);
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(HOLD_TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SET_W-1:0]  SETTLE_ONE  = SET_W'(1);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [1:0]         r_cpu_speed, w_speed_nxt;
    logic [1:0]         r_target, w_target_nxt;
    logic               r_pend_valid, w_pend_valid_nxt;
    logic [1:0]         r_pend_speed, w_pend_speed_nxt;
    logic [HOLD_W-1:0]  r_hold_cnt, w_hold_cnt_nxt;
    logic [SET_W-1:0]   r_settle_cnt, w_settle_cnt_nxt;
    logic               r_timeout, w_timeout_nxt;
    logic               r_ack, w_ack_nxt, w_ack_eq;
    logic               r_busy, w_busy_nxt;
    logic               r_contend;
    logic               w_cand_valid;
    logic [1:0]         w_cand_speed;
    logic [PHASE_W-1:0] w_phase;
    logic               w_clk_lsb;

    cpu_phase_gen u_phase_gen (
        .clk_28      (clk_28),
        .reset       (reset),
        .phase       (w_phase),
        .cpu_clk_lsb (w_clk_lsb)
    );

    // State register.
    always_ff @(posedge clk_28 or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_speed_nxt      = r_cpu_speed;
        w_target_nxt     = r_target;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_speed_nxt = r_pend_speed;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_settle_cnt_nxt = r_settle_cnt;
        w_timeout_nxt    = r_timeout;
        w_ack_eq         = 1'b0;
        // A strobe in the DONE cycle beats an older pending request.
        w_cand_valid     = speed_req_valid | r_pend_valid;
        w_cand_speed     = speed_req_valid ? speed_req : r_pend_speed;

        // Mid-sequence requests park in the pending slot, newest wins.
        if ((r_state != ST_IDLE) && speed_req_valid) begin
            w_pend_valid_nxt = 1'b1;
            w_pend_speed_nxt = speed_req;
        end else begin
            w_pend_valid_nxt = r_pend_valid;
        end

        case (r_state)
            ST_IDLE: begin
                if (speed_req_valid && (speed_req != r_cpu_speed)) begin
                    w_target_nxt   = speed_req;
                    w_hold_cnt_nxt = HOLD_ONE;
                    w_state_nxt    = ST_HOLD;
                end else if (speed_req_valid) begin
                    w_ack_eq = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // hold count includes the current cycle, so HOLD lasts at
                // most HOLD_TIMEOUT cycles; >= keeps it saturating.
                if (cpu_safe && (w_phase == 3'd0)) begin
                    w_state_nxt = ST_SW_LO;
                end else if (r_hold_cnt >= HOLD_MAX) begin
                    w_state_nxt   = ST_SW_LO;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + HOLD_ONE;
                end
            end
            ST_SW_LO: begin
                w_settle_cnt_nxt = {SET_W{1'b0}};
                if (r_target[0] != r_cpu_speed[0]) begin
                    w_speed_nxt = {r_cpu_speed[1], r_target[0]};
                    w_state_nxt = ST_SETTLE_LO;
                end else begin
                    w_state_nxt = ST_SW_HI;
                end
            end
            ST_SETTLE_LO: begin
                if (r_settle_cnt >= SETTLE_LAST) begin
                    w_state_nxt = ST_SW_HI;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt + SETTLE_ONE;
                end
            end
            ST_SW_HI: begin
                w_settle_cnt_nxt = {SET_W{1'b0}};
                if (r_target[1] != r_cpu_speed[1]) begin
                    w_speed_nxt = {r_target[1], r_cpu_speed[0]};
                    w_state_nxt = ST_SETTLE_HI;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_SETTLE_HI: begin
                if (r_settle_cnt >= SETTLE_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt + SETTLE_ONE;
                end
            end
            ST_DONE: begin
                w_pend_valid_nxt = 1'b0;
                if (w_cand_valid && (w_cand_speed != r_cpu_speed)) begin
                    w_target_nxt   = w_cand_speed;
                    w_hold_cnt_nxt = HOLD_ONE;
                    w_state_nxt    = ST_HOLD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // speed_ack is high exactly during the DONE cycle (or one cycle after
        // a request that already matches).
        w_ack_nxt  = w_ack_eq | (w_state_nxt == ST_DONE);
        w_busy_nxt = (w_state_nxt != ST_IDLE) | w_pend_valid_nxt;
    end

    // Datapath and output registers.
    always_ff @(posedge clk_28 or posedge reset) begin
        if (reset) begin
            r_cpu_speed  <= SPEED_3M5;
            r_target     <= SPEED_3M5;
            r_pend_valid <= 1'b0;
            r_pend_speed <= SPEED_3M5;
            r_hold_cnt   <= {HOLD_W{1'b0}};
            r_settle_cnt <= {SET_W{1'b0}};
            r_timeout    <= 1'b0;
            r_ack        <= 1'b0;
            r_busy       <= 1'b0;
            r_contend    <= 1'b0;
        end else begin
            r_cpu_speed  <= w_speed_nxt;
            r_target     <= w_target_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_speed <= w_pend_speed_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_timeout    <= w_timeout_nxt;
            r_ack        <= w_ack_nxt;
            r_busy       <= w_busy_nxt;
            r_contend    <= contend_in & contention_en &
                            contention_allowed(r_cpu_speed, r_busy);
        end
    end

    assign cpu_speed    = r_cpu_speed;
    assign cpu_clk_lsb  = w_clk_lsb;
    assign cpu_contend  = r_contend;
    assign busy         = r_busy;
    assign speed_ack    = r_ack;
    assign timeout_flag = r_timeout;

endmodule

// File: tb/tb_cpu_speed_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_speed_sequencer
// Directed stimulus with a schedule-based reference model: once a switch is
// released from the hold phase, the model computes on which relative cycle
// each speed bit changes and when the acknowledge occurs, and checks every
// output on every falling edge. Literal expectations pin key latencies.
// -----------------------------------------------------------------------------
module tb_cpu_speed_sequencer;

    localparam int SETTLE  = 8;
    localparam int HOLD_TO = 255;

    logic       clk_28;
    logic       reset;
    logic [1:0] speed_req;
    logic       speed_req_valid;
    logic       cpu_safe;
    logic       contend_in;
    logic       contention_en;
    logic [1:0] cpu_speed;
    logic       cpu_clk_lsb;
    logic       cpu_contend;
    logic       busy;
    logic       speed_ack;
    logic       timeout_flag;

    int n_checks;
    int n_errors;

    // reference model state
    logic [1:0] m_speed, m_target, m_ps;
    logic       m_pv, m_ack, m_busy, m_contend, m_timeout, m_lo, m_hi;
    logic [2:0] m_phase;
    int         m_job;   // 0 idle, 1 waiting for a safe point, 2 switching
    int         m_hold;  // hold cycles elapsed including the current one
    int         m_k;     // cycles since the low-bit switch slot

    cpu_speed_sequencer #(.SETTLE_CYCLES(SETTLE), .HOLD_TIMEOUT(HOLD_TO)) dut (
        .clk_28          (clk_28),
        .reset           (reset),
        .speed_req       (speed_req),
        .speed_req_valid (speed_req_valid),
        .cpu_safe        (cpu_safe),
        .contend_in      (contend_in),
        .contention_en   (contention_en),
        .cpu_speed       (cpu_speed),
        .cpu_clk_lsb     (cpu_clk_lsb),
        .cpu_contend     (cpu_contend),
        .busy            (busy),
        .speed_ack       (speed_ack),
        .timeout_flag    (timeout_flag)
    );

    initial clk_28 = 1'b0;
    always #5 clk_28 = ~clk_28;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic model_reset();
        m_speed = 2'b00; m_target = 2'b00; m_ps = 2'b00; m_pv = 1'b0;
        m_ack = 1'b0; m_busy = 1'b0; m_contend = 1'b0; m_timeout = 1'b0;
        m_lo = 1'b0; m_hi = 1'b0; m_phase = 3'd0;
        m_job = 0; m_hold = 0; m_k = 0;
    endtask

    // Predict the outputs after the next rising edge from the current inputs.
    task automatic model_step();
        logic [1:0] o_speed;
        logic       o_busy, n_ack, cand_v;
        logic [1:0] cand;
        logic [2:0] o_phase;
        int         kh, kd;
        if (reset) begin
            model_reset();
            return;
        end
        o_speed = m_speed; o_busy = m_busy; o_phase = m_phase;
        n_ack = 1'b0;
        m_contend = contend_in & contention_en & (o_speed == 2'b00) & ~o_busy;
        m_phase = o_phase + 3'd1;
        if (m_job == 0) begin
            if (speed_req_valid) begin
                if (speed_req != o_speed) begin
                    m_target = speed_req; m_job = 1; m_hold = 1;
                end else begin
                    n_ack = 1'b1;
                end
            end
        end else if (m_job == 1) begin
            if (speed_req_valid) begin m_pv = 1'b1; m_ps = speed_req; end
            if (cpu_safe && o_phase == 3'd0) begin
                m_job = 2; m_k = 0;
            end else if (m_hold == HOLD_TO) begin
                m_job = 2; m_k = 0; m_timeout = 1'b1;
            end else begin
                m_hold++;
            end
            m_lo = m_target[0] != o_speed[0];
            m_hi = m_target[1] != o_speed[1];
        end else begin
            kh = m_lo ? 1 + SETTLE : 1;
            kd = kh + 1 + (m_hi ? SETTLE : 0);
            if (m_k == 0 && m_lo) m_speed[0] = m_target[0];
            if (m_k == kh && m_hi) m_speed[1] = m_target[1];
            if (m_k == kd) begin
                cand_v = speed_req_valid | m_pv;
                cand   = speed_req_valid ? speed_req : m_ps;
                m_pv   = 1'b0;
                if (cand_v && cand != o_speed) begin
                    m_target = cand; m_job = 1; m_hold = 1;
                end else begin
                    m_job = 0;
                end
            end else begin
                if (speed_req_valid) begin m_pv = 1'b1; m_ps = speed_req; end
                m_k++;
                if (m_k == kd) n_ack = 1'b1;
            end
        end
        m_ack  = n_ack;
        m_busy = (m_job != 0) || m_pv;
    endtask

    task automatic check_outputs();
        chk("cpu_speed", cpu_speed, m_speed);
        chk("cpu_clk_lsb", cpu_clk_lsb, m_phase[2]);
        chk("cpu_contend", cpu_contend, m_contend);
        chk("busy", busy, m_busy);
        chk("speed_ack", speed_ack, m_ack);
        chk("timeout_flag", timeout_flag, m_timeout);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_28);
        @(negedge clk_28);
        check_outputs();
    endtask

    task automatic strobe(input logic [1:0] s);
        speed_req = s;
        speed_req_valid = 1'b1;
        cycle();
        speed_req_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic wait_change(input int limit, output int n);
        logic [1:0] s0;
        s0 = cpu_speed;
        n = 0;
        while (cpu_speed == s0 && n < limit) begin cycle(); n++; end
        if (cpu_speed == s0) fail_bound("wait_speed_change");
    endtask

    task automatic wait_ack(input int limit, output int n);
        n = 0;
        while (!speed_ack && n < limit) begin cycle(); n++; end
        if (!speed_ack) fail_bound("wait_speed_ack");
    endtask

    task automatic wait_flag(input int limit, output int n);
        n = 0;
        while (!timeout_flag && n < limit) begin cycle(); n++; end
        if (!timeout_flag) fail_bound("wait_timeout_flag");
    endtask

    initial begin
        int n;
        int seen10;
        int acks;
        n_checks = 0; n_errors = 0;
        reset = 1'b1; speed_req = 2'b00; speed_req_valid = 1'b0;
        cpu_safe = 1'b0; contend_in = 1'b0; contention_en = 1'b0;
        model_reset();
        @(negedge clk_28);
        check_outputs();
        chk("reset_speed", cpu_speed, 0);
        chk("reset_busy", busy, 0);
        cycle();
        reset = 1'b0;
        cycle();

        // 00 -> 11: low bit, 8 settle cycles, high bit, 8 settle cycles, ack
        cpu_safe = 1'b1;
        strobe(2'b11);
        wait_change(40, n);
        chk("first_step_01", cpu_speed, 1);
        wait_change(40, n);
        chk("lo_to_hi_gap", n, 9);
        chk("second_step_11", cpu_speed, 3);
        wait_ack(40, n);
        chk("hi_to_ack_gap", n, 8);
        cycle();
        chk("busy_low_after_ack", busy, 0);
        chk("ack_one_cycle", speed_ack, 0);

        // 11 -> 01: only the high bit moves, one settle period
        strobe(2'b01);
        wait_change(40, n);
        chk("hi_only_step", cpu_speed, 1);
        wait_ack(40, n);
        chk("hi_only_ack_gap", n, 8);
        cycle();

        // equal request: immediate ack, never busy
        strobe(2'b01);
        chk("equal_req_ack", speed_ack, 1);
        chk("equal_req_busy", busy, 0);
        cycle();

        // 01 then 10, 11 while busy: 10 is overwritten and never applied
        do_reset();
        cycle();
        strobe(2'b01);
        strobe(2'b10);
        strobe(2'b11);
        seen10 = 0; acks = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (cpu_speed == 2'b10) seen10 = 1;
            if (speed_ack) acks++;
        end
        chk("pending_final_speed", cpu_speed, 3);
        chk("overwritten_never_seen", seen10, 0);
        chk("pending_ack_count", acks, 2);
        chk("pending_idle_busy", busy, 0);

        // request arriving in the DONE cycle is serviced straight away
        strobe(2'b00);
        wait_ack(60, n);
        speed_req = 2'b01;
        speed_req_valid = 1'b1;
        cycle();
        speed_req_valid = 1'b0;
        chk("done_req_busy", busy, 1);
        wait_ack(60, n);
        chk("done_req_speed", cpu_speed, 1);
        cycle();

        // cpu_safe low: forced switch after HOLD_TO hold cycles
        cpu_safe = 1'b0;
        strobe(2'b10);
        wait_flag(400, n);
        chk("timeout_latency", n, 255);
        wait_change(10, n);
        chk("forced_switch_gap", n, 1);
        wait_ack(60, n);
        chk("forced_final_speed", cpu_speed, 2);
        cpu_safe = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("timeout_sticky", timeout_flag, 1);

        // contention qualification
        do_reset();
        chk("timeout_cleared", timeout_flag, 0);
        contend_in = 1'b1; contention_en = 1'b1;
        cycle();
        chk("contend_idle_00", cpu_contend, 1);
        strobe(2'b01);
        cycle();
        chk("contend_busy", cpu_contend, 0);
        wait_ack(60, n);
        cycle();
        chk("contend_after_01", cpu_contend, 0);
        contention_en = 1'b0;
        cycle();
        contend_in = 1'b0;

        // reset during the high-bit settle abandons the change
        do_reset();
        strobe(2'b11);
        wait_change(40, n);
        wait_change(40, n);
        cycle(); cycle(); cycle();
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_reset_speed", cpu_speed, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_ack", speed_ack, 0);
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        chk("post_reset_speed", cpu_speed, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
